// File: rtl/twiddle_rom_fetch.sv
// Twiddle ROM fetch: one request issues FOLD address phases per channel and gathers
// the returned ROM rows into a single twiddle set held until the consumer takes it.
module twiddle_rom_fetch #(
  parameter int D_WIDTH = 64,
  parameter int WPR     = 2,
  parameter int N_BANK  = 2,
  parameter int N_CH    = 3,
  parameter int FOLD    = 4,
  parameter int MA_W    = 4,
  parameter int ROM_LAT = 1,
  localparam int PH_W   = $clog2(FOLD),
  localparam int N_OUT  = FOLD * N_BANK * WPR,
  localparam int ROMA_W = MA_W + PH_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_CH*MA_W-1:0]               ma,
  output logic                               rom_cen,
  output logic [N_CH*ROMA_W-1:0]             rom_addr,
  input  logic [N_CH*N_BANK*WPR*D_WIDTH-1:0] rom_q,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_CH*N_OUT*D_WIDTH-1:0]      out_data
);

  localparam int OUT_W = N_CH * N_OUT * D_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_e;

  state_e                        state_q, state_d;
  logic [PH_W-1:0]               phase_q, phase_d;
  logic [1:0]                    drain_q, drain_d;
  logic [N_CH*MA_W-1:0]          ma_q, ma_d;
  logic [ROM_LAT-1:0]            pv_q, pv_d;
  logic [ROM_LAT-1:0][PH_W-1:0]  pp_q, pp_d;
  logic [OUT_W-1:0]              cap_q, cap_d;
  logic [OUT_W-1:0]              out_data_q, out_data_d;
  logic                          issue;
  logic                          commit;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    drain_d   = drain_q;
    ma_d      = ma_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_cen   = 1'b1;
    issue     = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ma_d    = ma;
          phase_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rom_cen = 1'b0;
        issue   = 1'b1;
        if (phase_q == PH_W'(FOLD - 1)) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(ROM_LAT - 1)) begin
          commit  = 1'b1;
          state_d = HOLD;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      phase_d = '0;
      drain_d = '0;
      commit  = 1'b0;
    end
  end

  always_comb begin
    rom_addr = '0;
    if (issue) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        rom_addr[c*ROMA_W +: ROMA_W] = {phase_q, ma_q[c*MA_W +: MA_W]};
      end
    end
  end

  // Each issued phase travels with its tag so the capture edge knows its output slot.
  always_comb begin
    pv_d    = '0;
    pp_d    = '0;
    pv_d[0] = issue;
    pp_d[0] = phase_q;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pp_d[i] = pp_q[i-1];
    end
    if (clr) begin
      pv_d = '0;
    end
  end

  // Rows land in a staging buffer; the visible set changes only when a full set is done.
  always_comb begin
    cap_d      = cap_q;
    out_data_d = out_data_q;
    if (pv_q[ROM_LAT-1] && !clr) begin
      for (int unsigned p = 0; p < FOLD; p++) begin
        if (pp_q[ROM_LAT-1] == PH_W'(p)) begin
          for (int unsigned c = 0; c < N_CH; c++) begin
            for (int unsigned b = 0; b < N_BANK; b++) begin
              for (int unsigned w = 0; w < WPR; w++) begin
                cap_d[(c*N_OUT + p*N_BANK*WPR + b*WPR + w)*D_WIDTH +: D_WIDTH] =
                  rom_q[((c*N_BANK + b)*WPR + w)*D_WIDTH +: D_WIDTH];
              end
            end
          end
        end
      end
    end
    if (commit) begin
      out_data_d = cap_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      drain_q    <= '0;
      ma_q       <= '0;
      pv_q       <= '0;
      pp_q       <= '0;
      cap_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      ma_q       <= ma_d;
      pv_q       <= pv_d;
      pp_q       <= pp_d;
      cap_q      <= cap_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_twiddle_rom_fetch.sv
// Bench for twiddle_rom_fetch: default instance (FOLD=4, ROM_LAT=1) plus a FOLD=8, ROM_LAT=3
// instance, both fed by ROM models returning a recognisable {channel,addr,bank,word} pattern.
module tb_twiddle_rom_fetch;

  localparam int DW = 64, WPR = 2, NB = 2, NCH = 3, MAW = 4;
  localparam int FA = 4, LA = 1, FB = 8, LB = 3;
  localparam int ROWS_W = NCH * NB * WPR * DW;
  localparam int RA_A = MAW + 2, RA_B = MAW + 3;
  localparam int NOUT_A = FA * NB * WPR, NOUT_B = FB * NB * WPR;
  localparam int OW_A = NCH * NOUT_A * DW, OW_B = NCH * NOUT_B * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 a_clr = 0, a_in_valid = 0, a_out_ready = 0;
  logic [NCH*MAW-1:0]   a_ma = '0;
  logic                 a_in_ready, a_rom_cen, a_out_valid;
  logic [NCH*RA_A-1:0]  a_rom_addr;
  logic [ROWS_W-1:0]    a_rom_q;
  logic [OW_A-1:0]      a_out_data;

  logic                 b_clr = 0, b_in_valid = 0, b_out_ready = 0;
  logic [NCH*MAW-1:0]   b_ma = '0;
  logic                 b_in_ready, b_rom_cen, b_out_valid;
  logic [NCH*RA_B-1:0]  b_rom_addr;
  logic [ROWS_W-1:0]    b_rom_q;
  logic [OW_B-1:0]      b_out_data;

  twiddle_rom_fetch #(.D_WIDTH(DW), .WPR(WPR), .N_BANK(NB), .N_CH(NCH), .FOLD(FA),
                      .MA_W(MAW), .ROM_LAT(LA)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ma(a_ma), .rom_cen(a_rom_cen), .rom_addr(a_rom_addr), .rom_q(a_rom_q),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));

  twiddle_rom_fetch #(.D_WIDTH(DW), .WPR(WPR), .N_BANK(NB), .N_CH(NCH), .FOLD(FB),
                      .MA_W(MAW), .ROM_LAT(LB)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ma(b_ma), .rom_cen(b_rom_cen), .rom_addr(b_rom_addr), .rom_q(b_rom_q),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [63:0] pat(int c, int addr, int b, int w);
    return {8'h5A, 8'(c), 16'(addr), 8'(b), 8'(w), 16'h1234};
  endfunction

  function automatic logic [ROWS_W-1:0] rom_rows(logic [20:0] addrv, int aw);
    logic [ROWS_W-1:0] r;
    int a;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      a = int'(addrv >> (c * aw)) & ((1 << aw) - 1);
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < WPR; w++)
          r[((c*NB + b)*WPR + w)*DW +: DW] = pat(c, a, b, w);
    end
    return r;
  endfunction

  // ROM models: disabled reads return all-ones so a mistimed capture is visible.
  logic [ROWS_W-1:0] a_s0, b_s0, b_s1, b_s2;
  always @(posedge clk) begin
    a_s0 <= a_rom_cen ? '1 : rom_rows(21'(a_rom_addr), RA_A);
    b_s0 <= b_rom_cen ? '1 : rom_rows(21'(b_rom_addr), RA_B);
    b_s1 <= b_s0;
    b_s2 <= b_s1;
  end
  assign a_rom_q = a_s0;
  assign b_rom_q = b_s2;

  // Reference: output word o of channel c comes from phase o/(NB*WPR), bank, word.
  function automatic logic [63:0] exp_word(int c, int o, logic [11:0] mav);
    int p, b, w, m;
    p = o / (NB * WPR);
    b = (o / WPR) % NB;
    w = o % WPR;
    m = int'(mav[c*MAW +: MAW]);
    return pat(c, p * (1 << MAW) + m, b, w);
  endfunction

  // Expected {in_ready, out_valid, rom_cen, rom_addr} in cycle k after an accept (k>=1).
  function automatic logic [63:0] exp_ctrl_a(int k, logic [11:0] mav);
    logic [NCH*RA_A-1:0] ad;
    logic iss;
    ad = '0;
    iss = (k >= 1) && (k <= FA);
    if (iss)
      for (int c = 0; c < NCH; c++)
        ad[c*RA_A +: RA_A] = {2'(k - 1), mav[c*MAW +: MAW]};
    return 64'({1'b0, (k >= FA + LA + 1), !iss, ad});
  endfunction

  function automatic logic [63:0] ctrl_a();
    return 64'({a_in_ready, a_out_valid, a_rom_cen, a_rom_addr});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_set(input string nm, input logic [OW_B-1:0] act, input logic [11:0] mav,
                         input int nout);
    int bad, fc, fo;
    logic [63:0] fa, fe, got;
    bad = 0; fc = 0; fo = 0; fa = '0; fe = '0;
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < nout; o++) begin
        got = act[(c*nout + o)*DW +: DW];
        if (got !== exp_word(c, o, mav)) begin
          if (bad == 0) begin fc = c; fo = o; fa = got; fe = exp_word(c, o, mav); end
          bad++;
        end
      end
    n_total++;
    if (bad == 0) n_pass++;
    else $display("FAIL %s: %0d words wrong, first ch%0d word%0d got %h expected %h",
                  nm, bad, fc, fo, fa, fe);
  endtask

  // Called at a negedge with instance A idle; returns at the negedge after the handshake.
  task automatic req_a(input logic [11:0] mav, input int stall, input bit poke);
    int to;
    to = 0;
    a_ma = mav; a_in_valid = 1'b1; a_out_ready = 1'b0;
    while (!a_in_ready && to < 20) begin @(negedge clk); to++; end
    chk("a_accept_ready", 64'(a_in_ready), 64'(1));
    @(negedge clk);
    a_in_valid = 1'b0;
    a_ma = 12'($urandom);
    for (int k = 1; k <= FA + LA + 1 + stall; k++) begin
      chk($sformatf("a_ctrl_k%0d", k), ctrl_a(), exp_ctrl_a(k, mav));
      if (k == FA + LA + 1) chk_set("a_set_hold", OW_B'(a_out_data), mav, NOUT_A);
      if (poke) a_in_valid = 1'($urandom);
      if (k == FA + LA + 1 + stall) begin
        a_out_ready = 1'b1;
        if (poke) a_in_valid = 1'b1;
      end
      @(negedge clk);
    end
    chk("a_idle_after_hs", 64'({a_in_ready, a_out_valid, a_rom_cen}), 64'(3'b101));
    chk_set("a_set_retained", OW_B'(a_out_data), mav, NOUT_A);
    a_out_ready = 1'b0;
    a_in_valid = 1'b0;
  endtask

  task automatic req_b(input logic [11:0] mav);
    int k, to;
    to = 0;
    b_ma = mav; b_in_valid = 1'b1;
    while (!b_in_ready && to < 20) begin @(negedge clk); to++; end
    chk("b_accept_ready", 64'(b_in_ready), 64'(1));
    @(negedge clk);
    b_in_valid = 1'b0;
    b_ma = 12'($urandom);
    k = 1;
    while (!b_out_valid && k < 40) begin @(negedge clk); k++; end
    chk("b_latency", 64'(k), 64'(FB + LB + 1));
    chk_set("b_set", b_out_data, mav, NOUT_B);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("b_idle_after_hs", 64'({b_in_ready, b_out_valid}), 64'(2'b10));
  endtask

  typedef struct {
    logic [11:0] ma;
    int          stall;
    bit          poke;
    logic [63:0] probe;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [11:0] last_ma, mv;
    logic [11:0] q[$];
    int nv, last_acc;

    vecs[0] = '{12'h953, 0, 1'b0, pat(1, 53, 0, 1)};
    vecs[1] = '{12'h000, 0, 1'b0, pat(1, 48, 0, 1)};
    vecs[2] = '{12'hFFF, 10, 1'b1, pat(1, 63, 0, 1)};
    vecs[3] = '{12'hA5C, 3, 1'b1, pat(1, 53, 0, 1)};
    vecs[4] = '{12'h3E1, 1, 1'b0, pat(1, 62, 0, 1)};

    #2 rst = 1'b0;
    #2;
    chk("rst_ctrl", ctrl_a(), 64'({1'b1, 1'b0, 1'b1, 18'd0}));
    chk("rst_out_data_a", 64'(|a_out_data), 64'(0));
    chk("rst_out_data_b", 64'(|b_out_data), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      req_a(vecs[i].ma, vecs[i].stall, vecs[i].poke);
      chk($sformatf("a_probe_ch1_w13_v%0d", i), a_out_data[(NOUT_A + 13)*DW +: DW], vecs[i].probe);
    end
    last_ma = vecs[4].ma;

    req_b(12'h953);
    req_b(12'($urandom));

    a_ma = 12'h7B2; a_in_valid = 1'b1;
    chk("clr_pre_ready", 64'(a_in_ready), 64'(1));
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_phase2_ctrl", ctrl_a(), exp_ctrl_a(3, 12'h7B2));
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("clr_idle_next", ctrl_a(), 64'({1'b1, 1'b0, 1'b1, 18'd0}));
    chk_set("clr_keeps_out_data", OW_B'(a_out_data), last_ma, NOUT_A);
    nv = 0;
    repeat (8) begin if (a_out_valid || !a_rom_cen) nv++; @(negedge clk); end
    chk("clr_no_activity", 64'(nv), 64'(0));
    a_in_valid = 1'b1; a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0; a_in_valid = 1'b0;
    chk("clr_blocks_accept", 64'({a_in_ready, a_rom_cen}), 64'(2'b11));
    req_a(12'h4C8, 0, 1'b0);

    q.delete();
    last_acc = -1;
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 56; cyc++) begin
      if (a_out_valid && a_out_ready) begin
        if (q.size() > 0) chk_set("b2b_set", OW_B'(a_out_data), q.pop_front(), NOUT_A);
        else chk("b2b_unexpected_set", 64'(1), 64'(0));
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(a_ma);
        if (last_acc >= 0) chk("b2b_period", 64'(cyc - last_acc), 64'(FA + LA + 2));
        last_acc = cyc;
      end
      if (cyc == 44) a_in_valid = 1'b0;
      if (!a_in_ready) a_ma = 12'($urandom);
      @(negedge clk);
    end
    chk("b2b_drained", 64'(q.size()), 64'(0));
    a_out_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      mv = 12'($urandom);
      req_a(mv, int'($urandom_range(0, 4)), 1'($urandom));
      last_ma = mv;
    end

    a_ma = 12'h1D6; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (FA) @(negedge clk);
    chk("rst_pre_drain_ctrl", ctrl_a(), exp_ctrl_a(FA + 1, 12'h1D6));
    chk_set("rst_pre_out_data", OW_B'(a_out_data), last_ma, NOUT_A);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ctrl", ctrl_a(), 64'({1'b1, 1'b0, 1'b1, 18'd0}));
    chk("rst_async_out_data", 64'(|a_out_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_recover_idle", 64'({a_in_ready, a_out_valid}), 64'(2'b10));
    req_a(12'h2A4, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/twiddle_rom_fetch.md
TWIDDLE_ROM_FETCH -- requirements
Module: twiddle_rom_fetch

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64, meaning twiddle word width.
REQ-002 SHALL have parameter WPR, default 2, meaning twiddle words per ROM row.
REQ-003 SHALL have parameter N_BANK, default 2, meaning ROM banks per channel.
REQ-004 SHALL have parameter N_CH, default 3, meaning independent ROM channels.
REQ-005 SHALL have parameter FOLD, default 4 (power of two, >=2), meaning address phases per request.
REQ-006 SHALL have parameter MA_W, default 4, meaning per-channel request address width.
REQ-007 SHALL have parameter ROM_LAT, default 1 (range 1..3), meaning ROM address-to-Q latency in cycles.
REQ-008 SHALL derive localparams N_OUT = FOLD*N_BANK*WPR and ROMA_W = MA_W + log2(FOLD).
REQ-009 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-010 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have port clr, input, 1, synchronous abort to IDLE.
REQ-012 SHALL have port in_valid, input, 1, request valid.
REQ-013 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-014 SHALL have port ma, input, N_CH*MA_W, channel c address at bits [c*MA_W +: MA_W].
REQ-015 SHALL have port rom_cen, output, 1, active-low ROM enable, shared by all banks.
REQ-016 SHALL have port rom_addr, output, N_CH*ROMA_W, channel c address, shared by all banks of channel c.
REQ-017 SHALL have port rom_q, input, N_CH*N_BANK*WPR*D_WIDTH, row of channel c, bank b at slice index (c*N_BANK+b).
REQ-018 SHALL have port out_valid, output, 1, twiddle set valid.
REQ-019 SHALL have port out_ready, input, 1, consumer accepts the set when out_valid && out_ready.
REQ-020 SHALL have port out_data, output, N_CH*N_OUT*D_WIDTH, channel c word o at index (c*N_OUT+o).

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN, HOLD.
REQ-022 SHALL drive in_ready=1 only in IDLE.
- On accept: register ma and go to ISSUE.
REQ-023 SHALL, in ISSUE, spend exactly FOLD cycles with phase p=0..FOLD-1.
- rom_cen=0 and rom_addr[c] = {p, ma_reg[c]}.
- Go to DRAIN after p=FOLD-1.
REQ-024 SHALL drive rom_cen=1 and rom_addr=0 in every state other than ISSUE.
REQ-025 SHALL capture rom_q for phase p at the clock edge ROM_LAT cycles after the edge that sampled phase p's address.
- Capture uses a phase-tagged ROM_LAT-deep shift pipeline, not a free-running counter.
REQ-026 SHALL write captured word w of bank b, phase p, channel c to out index o = p*N_BANK*WPR + b*WPR + w.
- Word w of a row is taken from row bits [w*D_WIDTH +: D_WIDTH].
REQ-027 SHALL stay in DRAIN for ROM_LAT cycles, then go to HOLD with out_valid=1.
REQ-028 SHALL hold out_data stable in HOLD until out_valid && out_ready, then return to IDLE.
REQ-029 Latency SHALL be: accept in cycle 0 gives out_valid first high in cycle FOLD+ROM_LAT+1.
REQ-030 SHALL give out_data=0 before the first completed request.
- After that, out_data retains the last set until the next set completes.
REQ-031 SHALL ignore in_valid outside IDLE, with no queuing.
REQ-032 clr SHALL force IDLE on the next edge from any state.
- clr discards in-flight captures and deasserts out_valid and rom_cen activity.
- clr does not clear out_data.
- clr has priority over accept and handshake in the same cycle.
REQ-033 A handshake in HOLD with in_valid=1 SHALL NOT accept the new request in that cycle; it is accepted the following cycle in IDLE.

Reset
REQ-034 rst=0 SHALL asynchronously set state=IDLE, in_ready=1, out_valid=0, rom_cen=1, rom_addr=0, out_data=0, and clear phase and capture pipeline.
REQ-035 Deassertion of rst SHALL take effect at the next rising edge; no request is accepted in the reset cycle.

Verification
REQ-036 Defaults, ROM model q = {addr,bank,word} pattern, ma={3,5,9}, out_ready=1:
- out_valid in cycle 6.
- Channel 1 word 13 equals the pattern for addr {3,5}, bank 0, word 1.
REQ-037 ROM_LAT=3, FOLD=8:
- out_valid in cycle 12.
- All N_OUT=32 words per channel map per REQ-026.
REQ-038 out_ready=0 for 10 cycles in HOLD:
- out_data stable, in_ready=0, in_valid pulses ignored.
- Release -> IDLE next cycle.
REQ-039 clr in ISSUE phase 2:
- IDLE next cycle, rom_cen=1, no out_valid.
- A following request completes with correct data.
REQ-040 rst=0 asserted mid-DRAIN:
- All outputs reach reset values immediately, without a clock edge.
REQ-041 Back-to-back in_valid=1, out_ready=1:
- One accept per FOLD+ROM_LAT+2 cycles.
- Sets delivered in order with no corruption.
